fp_unpack_pipe: RTL and testbench

//  Reverse of sign injection/packing: splits an IEEE-754 single/double operand into sign, unbiased exponent,

---
 rtl/fp_unpack_pipe_pkg.sv | 44 ++++
 rtl/fp_unpack_pipe_lzc.sv | 20 ++
 rtl/fp_unpack_pipe.sv | 190 +++++++++++++++++++
 tb/tb_fp_unpack_pipe.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_unpack_pipe_pkg.sv
// Shared constants and stage-1 register layout for the fp_unpack_pipe slice.
//   fp_cons : exponent biases, format codes and RISC-V fclass bit indices.
//   fp_wire : fp_unpack_s1_type, the contents of the stage-1 pipeline register.
// No ports; imported by fp_unpack_pipe.

package fp_cons;

    localparam logic [12:0] BIAS_S = 13'd127;
    localparam logic [12:0] BIAS_D = 13'd1023;

    localparam logic [1:0] FMT_S = 2'd0;
    localparam logic [1:0] FMT_D = 2'd1;

    localparam int unsigned FCLASS_NEG_INF  = 0;
    localparam int unsigned FCLASS_NEG_NORM = 1;
    localparam int unsigned FCLASS_NEG_SUB  = 2;
    localparam int unsigned FCLASS_NEG_ZERO = 3;
    localparam int unsigned FCLASS_POS_ZERO = 4;
    localparam int unsigned FCLASS_POS_SUB  = 5;
    localparam int unsigned FCLASS_POS_NORM = 6;
    localparam int unsigned FCLASS_POS_INF  = 7;
    localparam int unsigned FCLASS_SNAN     = 8;
    localparam int unsigned FCLASS_QNAN     = 9;

endpackage

package fp_wire;

    // Raw fields plus precomputed flags; the fraction is always left-aligned
    // to 52 bits so stage 2 treats single and double identically apart from bias.
    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] frac;
        logic        is_double;
        logic        illegal;
        logic        exp_zero;
        logic        exp_ones;
        logic        frac_zero;
        logic        quiet;
        logic [5:0]  lzc;
    } fp_unpack_s1_type;

endpackage

// File: rtl/fp_unpack_pipe_lzc.sv
// fp_unpack_lzc: combinational leading-zero count of a 52-bit fraction.
//   frac in  52  left-aligned fraction
//   lzc  out 6   number of leading zeros from bit 51; 52 when frac is all zero

module fp_unpack_lzc (
    input  logic [51:0] frac,
    output logic [5:0]  lzc
);

    // Scanning upward lets the highest set bit win.
    always_comb begin
        lzc = 6'd52;
        for (int unsigned i = 0; i < 52; i++) begin
            if (frac[i]) begin
                lzc = 6'(51 - i);
            end
        end
    end

endmodule

// File: rtl/fp_unpack_pipe.sv
// fp_unpack_pipe: splits an IEEE-754 single/double operand into sign, unbiased
// exponent, normalized 53-bit significand and RISC-V fclass one-hot, through a
// 2-stage valid/ready pipeline (latency 2, throughput 1/cycle).
// Ports:
//   clock, reset (async, active-high)
//   in_valid/in_ready, data[63:0], fmt[1:0] (0=single, 1=double, 2/3=illegal)
//   out_valid/out_ready, sign, exponent[12:0] (two's complement),
//   mantissa[52:0], fclass[9:0], illegal
// Build option: FP_UNPACK_NAN_BOX_EN -- single operands whose data[63:32] is not
// all ones are replaced by the canonical quiet NaN. Undefined: upper half ignored.

module fp_unpack_pipe
    import fp_cons::*;
    import fp_wire::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data,
    input  logic [1:0]  fmt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign,
    output logic [12:0] exponent,
    output logic [52:0] mantissa,
    output logic [9:0]  fclass,
    output logic        illegal
);

    fp_unpack_s1_type s1_fields;
    logic [5:0]       lzc_in;

    fp_unpack_s1_type s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic             sign_q, sign_d;
    logic [12:0]      exponent_q, exponent_d;
    logic [52:0]      mantissa_q, mantissa_d;
    logic [9:0]       fclass_q, fclass_d;
    logic             illegal_q, illegal_d;

    logic             s1_adv, s2_adv;

    logic             c_sign;
    logic [12:0]      c_exp;
    logic [52:0]      c_mant;
    logic [9:0]       c_class;
    logic             c_illegal;
    logic [12:0]      bias;

    // ---------------- stage 1: field extraction ----------------
    always_comb begin
        s1_fields = '0;
        case (fmt)
            FMT_S: begin
                s1_fields.sign     = data[31];
                s1_fields.exp      = {3'b000, data[30:23]};
                s1_fields.frac     = {data[22:0], 29'b0};
                s1_fields.exp_zero = (data[30:23] == 8'h00);
                s1_fields.exp_ones = (&data[30:23]);
`ifdef FP_UNPACK_NAN_BOX_EN
                // Improperly boxed single: present it as the canonical qNaN.
                if (data[63:32] != '1) begin
                    s1_fields.sign     = 1'b0;
                    s1_fields.frac     = 52'h8000000000000;
                    s1_fields.exp_zero = 1'b0;
                    s1_fields.exp_ones = 1'b1;
                end
`endif
            end
            FMT_D: begin
                s1_fields.is_double = 1'b1;
                s1_fields.sign      = data[63];
                s1_fields.exp       = data[62:52];
                s1_fields.frac      = data[51:0];
                s1_fields.exp_zero  = (data[62:52] == 11'h000);
                s1_fields.exp_ones  = (&data[62:52]);
            end
            default: begin
                s1_fields.illegal = 1'b1;
            end
        endcase
        s1_fields.frac_zero = (s1_fields.frac == '0);
        s1_fields.quiet     = s1_fields.frac[51];
    end

    fp_unpack_lzc u_lzc (
        .frac (s1_fields.frac),
        .lzc  (lzc_in)
    );

    // ---------------- handshake ----------------
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    assign in_ready = s1_adv;

    always_comb begin
        s1_d = s1_q;
        if (in_valid && s1_adv) begin
            s1_d     = s1_fields;
            s1_d.lzc = lzc_in;
        end
    end

    // ---------------- stage 2: classification ----------------
    always_comb begin
        bias      = s1_q.is_double ? BIAS_D : BIAS_S;
        c_sign    = s1_q.sign;
        c_exp     = '0;
        c_mant    = '0;
        c_class   = '0;
        c_illegal = 1'b0;
        if (s1_q.illegal) begin
            c_illegal = 1'b1;
            c_sign    = 1'b0;
        end else if (s1_q.exp_ones) begin
            if (s1_q.frac_zero) begin
                c_class = 10'b1 << (s1_q.sign ? FCLASS_NEG_INF : FCLASS_POS_INF);
            end else begin
                c_mant  = {1'b0, s1_q.frac};
                c_class = 10'b1 << (s1_q.quiet ? FCLASS_QNAN : FCLASS_SNAN);
            end
        end else if (s1_q.exp_zero) begin
            if (s1_q.frac_zero) begin
                c_class = 10'b1 << (s1_q.sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO);
            end else begin
                // 1 - bias - (lzc + 1) folds to -bias - lzc.
                c_exp   = 13'd0 - bias - {7'b0, s1_q.lzc};
                c_mant  = {1'b0, s1_q.frac} << ({1'b0, s1_q.lzc} + 7'd1);
                c_class = 10'b1 << (s1_q.sign ? FCLASS_NEG_SUB : FCLASS_POS_SUB);
            end
        end else begin
            c_exp   = {2'b00, s1_q.exp} - bias;
            c_mant  = {1'b1, s1_q.frac};
            c_class = 10'b1 << (s1_q.sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM);
        end
    end

    always_comb begin
        sign_d     = sign_q;
        exponent_d = exponent_q;
        mantissa_d = mantissa_q;
        fclass_d   = fclass_q;
        illegal_d  = illegal_q;
        if (s2_adv && s1_valid_q) begin
            sign_d     = c_sign;
            exponent_d = c_exp;
            mantissa_d = c_mant;
            fclass_d   = c_class;
            illegal_d  = c_illegal;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            sign_q     <= 1'b0;
            exponent_q <= '0;
            mantissa_q <= '0;
            fclass_q   <= '0;
            illegal_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s1_q       <= s1_d;
            sign_q     <= sign_d;
            exponent_q <= exponent_d;
            mantissa_q <= mantissa_d;
            fclass_q   <= fclass_d;
            illegal_q  <= illegal_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sign      = sign_q;
    assign exponent  = exponent_q;
    assign mantissa  = mantissa_q;
    assign fclass    = fclass_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Self-checking bench for fp_unpack_pipe: directed vectors, randomized traffic
// with random back-pressure against a value-level IEEE-754 reference model,
// back-to-back stall scenario, illegal formats and reset with ops in flight.

module tb_fp_unpack_pipe;

    typedef struct packed {
        logic        sign;
        logic [12:0] exponent;
        logic [52:0] mantissa;
        logic [9:0]  fclass;
        logic        illegal;
    } res_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data;
    logic [1:0]  fmt;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [12:0] exponent;
    logic [52:0] mantissa;
    logic [9:0]  fclass;
    logic        illegal;

    int errors = 0;
    int checks = 0;
    res_t exp_q[$];

    fp_unpack_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data      (data),
        .fmt       (fmt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .exponent  (exponent),
        .mantissa  (mantissa),
        .fclass    (fclass),
        .illegal   (illegal)
    );

    always #5 clock = ~clock;

    function automatic res_t dut_out();
        res_t r;
        r.sign     = sign;
        r.exponent = exponent;
        r.mantissa = mantissa;
        r.fclass   = fclass;
        r.illegal  = illegal;
        return r;
    endfunction

    // Value-level model: interpret the operand numerically and express it as
    // 1.xxx * 2^exponent with the leading one at bit 52.
    function automatic res_t model(input logic [1:0] f, input logic [63:0] d);
        res_t r;
        int fw, ew, bias, e, emax, p, ex;
        longint unsigned frac;
        logic s;
        r = '0;
        if (f > 2'd1) begin
            r.illegal = 1'b1;
            return r;
        end
`ifdef FP_UNPACK_NAN_BOX_EN
        if (f == 2'd0 && d[63:32] != 32'hFFFF_FFFF) begin
            r.mantissa = 53'(64'(1) << 51);
            r.fclass   = 10'(1) << 9;
            return r;
        end
`endif
        fw   = (f == 2'd1) ? 52 : 23;
        ew   = (f == 2'd1) ? 11 : 8;
        bias = (1 << (ew - 1)) - 1;
        emax = (1 << ew) - 1;
        s    = (f == 2'd1) ? d[63] : d[31];
        e    = (f == 2'd1) ? int'(d[62:52]) : int'(d[30:23]);
        frac = (f == 2'd1) ? longint'(d[51:0]) : longint'(d[22:0]);
        r.sign = s;
        if (e == emax) begin
            if (frac == 0) begin
                r.fclass = 10'(1) << (s ? 0 : 7);
            end else begin
                r.mantissa = 53'(frac << (52 - fw));
                r.fclass   = 10'(1) << (frac[fw-1] ? 9 : 8);
            end
        end else if (e == 0) begin
            if (frac == 0) begin
                r.fclass = 10'(1) << (s ? 3 : 4);
            end else begin
                p = 0;
                for (int i = 0; i < fw; i++) if (frac[i]) p = i;
                ex = p + 1 - bias - fw;
                r.exponent = 13'(ex);
                r.mantissa = 53'(frac << (52 - p));
                r.fclass   = 10'(1) << (s ? 2 : 5);
            end
        end else begin
            r.exponent = 13'(e - bias);
            r.mantissa = 53'(((64'(1) << fw) | frac) << (52 - fw));
            r.fclass   = 10'(1) << (s ? 1 : 6);
        end
        return r;
    endfunction

    task automatic gen(output logic [1:0] f, output logic [63:0] d);
        int sel;
        sel = $urandom_range(0, 9);
        f = (sel == 0) ? 2'($urandom_range(2, 3)) : ((sel < 5) ? 2'd0 : 2'd1);
        d = {$urandom, $urandom};
        if (f == 2'd1) begin
            case ($urandom_range(0, 3))
                0: d[62:52] = '0;
                1: d[62:52] = '1;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) d[51:0] = '0;
            else if ($urandom_range(0, 2) == 0) d[51:0] = 52'(64'(1) << $urandom_range(0, 51));
        end else begin
            case ($urandom_range(0, 3))
                0: d[30:23] = '0;
                1: d[30:23] = '1;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) d[22:0] = '0;
            else if ($urandom_range(0, 2) == 0) d[22:0] = 23'(32'(1) << $urandom_range(0, 22));
            if ($urandom_range(0, 3) != 0) d[63:32] = '1;
        end
    endtask

    task automatic test_reset();
        res_t o;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        o = dut_out();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid);
        end
        checks++;
        if (o !== '0) begin
            errors++; $display("FAIL reset_outputs got %h expected 0", o);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [63:0] vd [11];
        logic [1:0]  vf [11];
        logic [9:0]  vc [11];
        int          ve [11];
        res_t o, e;
        int n;
        vd[0]  = 64'h3FF0000000000000; vf[0]  = 2'd1; vc[0]  = 10'h040; ve[0]  = 0;
        vd[1]  = 64'hFFFFFFFF00000001; vf[1]  = 2'd0; vc[1]  = 10'h020; ve[1]  = -149;
        vd[2]  = 64'hFFF0000000000000; vf[2]  = 2'd1; vc[2]  = 10'h001; ve[2]  = 0;
        vd[3]  = 64'h7FF4000000000000; vf[3]  = 2'd1; vc[3]  = 10'h100; ve[3]  = 0;
        vd[4]  = 64'hFFFFFFFF00400000; vf[4]  = 2'd0; vc[4]  = 10'h020; ve[4]  = -127;
        vd[5]  = 64'h8000000000000000; vf[5]  = 2'd1; vc[5]  = 10'h008; ve[5]  = 0;
`ifdef FP_UNPACK_NAN_BOX_EN
        vd[6]  = 64'h0000000040490FDB; vf[6]  = 2'd0; vc[6]  = 10'h200; ve[6]  = 0;
`else
        vd[6]  = 64'h0000000040490FDB; vf[6]  = 2'd0; vc[6]  = 10'h040; ve[6]  = 1;
`endif
        vd[7]  = 64'hFFF8123456789ABC; vf[7]  = 2'd2; vc[7]  = 10'h000; ve[7]  = 0;
        vd[8]  = 64'h3FF0000000000000; vf[8]  = 2'd3; vc[8]  = 10'h000; ve[8]  = 0;
        vd[9]  = 64'h0000000000000001; vf[9]  = 2'd1; vc[9]  = 10'h020; ve[9]  = -1074;
        vd[10] = 64'hFFFFFFFF7FC00000; vf[10] = 2'd0; vc[10] = 10'h200; ve[10] = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clock); #1;
            in_valid = 1'b1; data = vd[i]; fmt = vf[i];
            @(posedge clock); #1;
            in_valid = 1'b0;
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!out_valid && n < 10);
            o = dut_out();
            e = model(vf[i], vd[i]);
            checks++;
            if (n !== 2) begin
                errors++; $display("FAIL dir%0d_latency got %0d expected 2", i, n);
            end
            checks++;
            if (o.fclass !== vc[i]) begin
                errors++; $display("FAIL dir%0d_fclass got %h expected %h", i, o.fclass, vc[i]);
            end
            checks++;
            if (o.exponent !== 13'(ve[i])) begin
                errors++; $display("FAIL dir%0d_exponent got %h expected %h", i, o.exponent, 13'(ve[i]));
            end
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL dir%0d_result got %h expected %h", i, o, e);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_random(input int num);
        int sent, got, cyc;
        logic pending;
        logic [1:0] f;
        logic [63:0] d;
        res_t o, e;
        sent = 0; got = 0; cyc = 0; pending = 1'b0;
        exp_q.delete();
        while ((sent < num || got < sent) && cyc < 20000) begin
            @(posedge clock); #1;
            if (!pending) begin
                if (sent < num && $urandom_range(0, 3) != 0) begin
                    gen(f, d);
                    fmt = f; data = d; in_valid = 1'b1; pending = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            if (out_valid && out_ready) begin
                o = dut_out();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_output got %h expected none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++; $display("FAIL rand_result got %h expected %h", o, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(fmt, data));
                sent++;
                pending = 1'b0;
            end
            cyc++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (cyc >= 20000 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_drain got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int sent, got, cyc;
        logic held_v;
        res_t held, o, e;
        logic [1:0] f;
        logic [63:0] d;
        sent = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
        exp_q.delete();
        while (got < 8 && cyc < 100) begin
            @(posedge clock); #1;
            if (sent < 8) begin
                gen(f, d);
                if (f > 2'd1) f = 2'd1;
                fmt = f; data = d; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clock);
            o = dut_out();
            if (held_v) begin
                checks++;
                if (out_valid !== 1'b1 || o !== held) begin
                    errors++; $display("FAIL b2b_stall_stable got %b/%h expected 1/%h", out_valid, o, held);
                end
            end
            held_v = out_valid && !out_ready;
            held = o;
            if (cyc < 3) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_in_ready cycle %0d got %b expected 1", cyc, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_dup_output got %h expected none", o);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++; $display("FAIL b2b_order got %h expected %h", o, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(fmt, data));
                sent++;
            end
            cyc++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        checks++;
        if (got != 8 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count got %0d expected 8", got);
        end
        // 8 ops, 2 cycles latency, 3 stall cycles: should be done within 14 cycles.
        checks++;
        if (cyc > 14) begin
            errors++; $display("FAIL b2b_cycles got %0d expected <=14", cyc);
        end
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b1; fmt = 2'd1; data = 64'h4000000000000000;
        @(posedge clock); #1;
        data = 64'hC008000000000000;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL inflight_setup got %b expected 1", out_valid);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_async_out_valid got %b expected 0", out_valid);
        end
        @(negedge clock);
        checks++;
        if (dut_out() !== '0) begin
            errors++; $display("FAIL reset_inflight_outputs got %h expected 0", dut_out());
        end
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_dropped_ops cycle %0d got %b expected 0", i, out_valid);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data = '0;
        fmt = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random(400);
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
